// File: rtl/pipelined_rv_core_param.sv
// pipelined_rv_core_param: 3-stage RV32I-subset core (fetch, execute, writeback); define RV_BRANCH_EN for BEQ/BNE with single-bubble flush
module pipelined_rv_core_param #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REGS   = 16,
   parameter int PM_DEPTH   = 32,
   parameter int PM_ADDR_W  = $clog2(PM_DEPTH * 4),
   parameter int PC_W       = $clog2(PM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  pm_wr_en,
   input  logic [PM_ADDR_W-1:0]  pm_addr,
   input  logic [7:0]            instruction_in,
   output logic [DATA_WIDTH-1:0] alu_result,
   output logic                  wb_valid,
   output logic [PC_W-1:0]       pc_out
);
   localparam int RW = $clog2(NUM_REGS);
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   logic [7:0] pm [PM_DEPTH*4];
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [PC_W-1:0] pc, next_pc;
   logic if_valid;
   logic [31:0] if_instr, fetch;
   logic [4:0] wb_rd, rd, rs1, rs2;
   logic [6:0] op, f7;
   logic [2:0] f3;
   logic [DATA_WIDTH-1:0] a, rv2, b, imm, res;
   logic sub, f3_ok, wr, flush;
   always_ff @(posedge clk)
      if (pm_wr_en) pm[pm_addr] <= instruction_in;
   assign fetch = {pm[{pc, 2'd3}], pm[{pc, 2'd2}], pm[{pc, 2'd1}], pm[{pc, 2'd0}]};
   assign {f7, rs2, rs1, f3, rd, op} = if_instr;
   assign imm = DATA_WIDTH'($signed(if_instr[31:20]));
   // WB forwarding per operand; x0 never forwards because WB never holds rd=0 as valid
   assign a   = (wb_valid && wb_rd != 5'd0 && wb_rd == rs1) ? alu_result :
                int'(rs1) < NUM_REGS ? regs[rs1[RW-1:0]] : '0;
   assign rv2 = (wb_valid && wb_rd != 5'd0 && wb_rd == rs2) ? alu_result :
                int'(rs2) < NUM_REGS ? regs[rs2[RW-1:0]] : '0;
   always_comb begin
      b     = op == OP_R ? rv2 : imm;
      sub   = op == OP_R && f7 == 7'b0100000;
      f3_ok = f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7;
      wr    = if_valid && rd != 5'd0 &&
              (op == OP_I ? f3_ok : op == OP_R && (f7 == 7'd0 ? f3_ok : sub && f3 == 3'd0));
      res   = f3 == 3'd0 ? (sub ? a - b : a + b) :
              f3 == 3'd2 ? DATA_WIDTH'($signed(a) < $signed(b)) :
              f3 == 3'd4 ? a ^ b :
              f3 == 3'd6 ? a | b : a & b;
   end
`ifdef RV_BRANCH_EN
   localparam logic [6:0] OP_B = 7'b1100011;
   logic [PC_W-1:0] if_pc;
   logic [12:0] imm_b;
   assign imm_b   = {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
   assign flush   = run && if_valid && op == OP_B && (f3 == 3'd0 ? a == rv2 : f3 == 3'd1 && a != rv2);
   assign next_pc = flush ? if_pc + PC_W'($signed(imm_b) >>> 2) : pc + 1'b1;
   always_ff @(posedge clk)
      if (rst) if_pc <= '0;
      else if (run) if_pc <= pc;
`else
   assign flush   = 1'b0;
   assign next_pc = pc + 1'b1;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= '0;
         if_valid   <= 1'b0;
         if_instr   <= '0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         alu_result <= '0;
      end else if (run) begin
         pc       <= next_pc;
         if_valid <= !flush;
         if_instr <= fetch;
         wb_valid <= wr;
         wb_rd    <= rd;
         if (wr) alu_result <= res;
      end else begin
         wb_valid <= 1'b0;
      end
   end
   // the pending WB write commits even while stalled
   always_ff @(posedge clk)
      if (rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (wb_valid && wb_rd != 5'd0 && int'(wb_rd) < NUM_REGS) regs[wb_rd[RW-1:0]] <= alu_result;
   assign pc_out = pc;
endmodule

// File: tb/tb_pipelined_rv_core_param.sv
// tb_pipelined_rv_core_param: scoreboard bench for pipelined_rv_core_param (honours RV_BRANCH_EN)
module tb_pipelined_rv_core_param;
   logic clk = 1'b0;
   logic rst, run, pm_wr_en;
   logic [6:0] pm_addr;
   logic [7:0] instruction_in;
   logic [7:0] alu_result;
   logic wb_valid;
   logic [4:0] pc_out;
   logic [31:0] prog [32];
   logic [7:0] exp_q [$];
   logic [7:0] sb_exp;
   int checks = 0;
   int errors = 0;
   pipelined_rv_core_param dut (
      .clk(clk), .rst(rst), .run(run), .pm_wr_en(pm_wr_en), .pm_addr(pm_addr),
      .instruction_in(instruction_in), .alu_result(alu_result), .wb_valid(wb_valid), .pc_out(pc_out)
   );
   always #5 clk = ~clk;
   always @(negedge clk)
      if (wb_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got result %0h, none expected", alu_result);
         end else begin
            sb_exp = exp_q.pop_front();
            if (alu_result !== sb_exp) begin
               errors++;
               $display("FAIL sb_result: got %0h want %0h", alu_result, sb_exp);
            end
         end
      end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic load_prog();
      for (int w = 0; w < 32; w++)
         for (int k = 0; k < 4; k++) begin
            pm_wr_en = 1'b1;
            pm_addr = 7'(w * 4 + k);
            instruction_in = prog[w][k*8 +: 8];
            step(1);
         end
      pm_wr_en = 1'b0;
   endtask
   initial begin
      rst = 1'b1; run = 1'b0; pm_wr_en = 1'b0; pm_addr = '0; instruction_in = '0;
      step(2);
      chk("rst_pc", 32'(pc_out), 0);
      chk("rst_valid", 32'(wb_valid), 0);
      chk("rst_result", 32'(alu_result), 0);
      for (int i = 0; i < 32; i++) prog[i] = 32'h00000013;
      prog[0]  = 32'h00500093; // addi x1,x0,5
      prog[1]  = 32'h00300113; // addi x2,x0,3
      prog[2]  = 32'h002081B3; // add  x3,x1,x2
      prog[3]  = 32'h40208233; // sub  x4,x1,x2
      prog[4]  = 32'h00700013; // addi x0,x0,7
      prog[5]  = 32'h00100293; // addi x5,x0,1
      prog[6]  = 32'h0041C333; // xor  x6,x3,x4
      prog[7]  = 32'h0020E3B3; // or   x7,x1,x2
      prog[8]  = 32'h0020F433; // and  x8,x1,x2
      prog[9]  = 32'hFFD00513; // addi x10,x0,-3
      prog[10] = 32'h001525B3; // slt  x11,x10,x1
      prog[11] = 32'hFFF0A613; // slti x12,x1,-1
      prog[12] = 32'h00F54693; // xori x13,x10,0xf
      prog[13] = 32'h03C57713; // andi x14,x10,0x3c
      prog[14] = 32'h0400E793; // ori  x15,x1,0x40
      prog[15] = 32'h40110333; // sub  x6,x2,x1
      prog[16] = 32'h00109393; // slli (unsupported)
      prog[17] = 32'h02208233; // mul  (unsupported)
      prog[18] = 32'h7FF20693; // addi x13,x4,0x7ff (imm truncates to 0xff)
      prog[19] = 32'h00578733; // add  x14,x15,x5
      load_prog();
      exp_q = '{8'd5, 8'd3, 8'd8, 8'd2, 8'd1, 8'd10, 8'd7, 8'd1, 8'hFD, 8'd1, 8'd0,
                8'hF2, 8'h3C, 8'h45, 8'hFE, 8'h01, 8'h46};
      rst = 1'b0; run = 1'b1;
      step(1);
      chk("e1_valid", 32'(wb_valid), 0);
      chk("e1_pc", 32'(pc_out), 1);
      step(1);
      chk("e2_pc", 32'(pc_out), 2);
      chk("e2_valid", 32'(wb_valid), 1);
      chk("e2_result", 32'(alu_result), 5);
      step(6);
      chk("pre_stall_pc", 32'(pc_out), 8);
      chk("pre_stall_result", 32'(alu_result), 10);
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("stall_pc", 32'(pc_out), 8);
         chk("stall_valid", 32'(wb_valid), 0);
         chk("stall_result", 32'(alu_result), 10);
      end
      run = 1'b1;
      step(23);
      chk("wrap_pc31", 32'(pc_out), 31);
      step(1);
      chk("wrap_pc0", 32'(pc_out), 0);
      exp_q.push_back(8'd5);
      step(2);
      rst = 1'b1;
      step(1);
      chk("midrst_pc", 32'(pc_out), 0);
      chk("midrst_result", 32'(alu_result), 0);
      chk("midrst_valid", 32'(wb_valid), 0);
      rst = 1'b0;
      exp_q = '{8'd5, 8'd3, 8'd8, 8'd2};
      step(5);
      run = 1'b0;
      step(2);
      rst = 1'b1;
      for (int i = 0; i < 32; i++) prog[i] = 32'h00000013;
      prog[0] = 32'h00100093; // addi x1,x0,1
      prog[1] = 32'h00108093; // addi x1,x1,1
      prog[2] = 32'h00900113; // addi x2,x0,9
      prog[3] = 32'hFE000CE3; // beq  x0,x0,-8
      prog[4] = 32'h05500193; // addi x3,x0,0x55
      load_prog();
`ifdef RV_BRANCH_EN
      exp_q = '{8'd1, 8'd2, 8'd9, 8'd3, 8'd9, 8'd4, 8'd9};
`else
      exp_q = '{8'd1, 8'd2, 8'd9, 8'h55};
`endif
      rst = 1'b0; run = 1'b1;
      step(5);
`ifdef RV_BRANCH_EN
      chk("branch_pc", 32'(pc_out), 1);
`else
      chk("branch_pc", 32'(pc_out), 5);
`endif
      step(7);
      run = 1'b0;
      step(2);
      chk("sb_drain", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
